// File: rtl/dsi_pkt_pkg.sv
// -----------------------------------------------------------------------------
// dsi_pkt_pkg
// Shared definitions for the DSI packet assembler: FSM state encoding,
// header/checksum byte counts and the bit positions of the VC and DT fields
// inside the Data Identifier byte.
// -----------------------------------------------------------------------------
package dsi_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } dsi_state_e;

    localparam int DSI_HDR_BYTES = 4;
    localparam int DSI_CRC_BYTES = 2;

    // Data Identifier layout: DI = {VC[1:0], DT[5:0]}
    localparam int DI_DT_LSB = 0;
    localparam int DI_DT_MSB = 5;
    localparam int DI_VC_LSB = 6;
    localparam int DI_VC_MSB = 7;

endpackage

// File: rtl/dsi_packet_assembler_if.sv
// -----------------------------------------------------------------------------
// dsi_packet_assembler_if
// Bundles the three handshake channels of the packet assembler:
//   pkt_*  : packet request (valid/ready, long flag, VC, DT, WC/data)
//   pl_*   : long-packet payload words (valid/ready, 32-bit data)
//   out_*  : output beats to lane distribution (valid/ready, data, bytes, last)
//   busy   : assembler is working on a packet
// slave  = assembler view, master = source/sink (testbench) view.
// -----------------------------------------------------------------------------
interface dsi_packet_assembler_if;

    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_long;
    logic [1:0]  pkt_vc;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;

    logic        pl_valid;
    logic        pl_ready;
    logic [31:0] pl_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_bytes;
    logic        out_last;

    logic        busy;

    modport slave (
        input  pkt_valid, pkt_long, pkt_vc, pkt_dt, pkt_wc,
        output pkt_ready,
        input  pl_valid, pl_data,
        output pl_ready,
        output out_valid, out_data, out_bytes, out_last,
        input  out_ready,
        output busy
    );

    modport master (
        output pkt_valid, pkt_long, pkt_vc, pkt_dt, pkt_wc,
        input  pkt_ready,
        output pl_valid, pl_data,
        input  pl_ready,
        input  out_valid, out_data, out_bytes, out_last,
        output out_ready,
        input  busy
    );

endinterface

// File: rtl/crc_calculator.sv
// -----------------------------------------------------------------------------
// crc_calculator
// Registered DSI payload checksum: CRC-16 x^16+x^12+x^5+1, LSB-first
// (reflected polynomial 0x8408), seed 0xFFFF, no final inversion.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset (CRC -> 0xFFFF)
//   clear             : synchronous re-seed to 0xFFFF (wins over data_write)
//   data_write        : fold bytes 0..bytes_number of data into the CRC
//   bytes_number[1:0] : valid bytes in data minus 1, byte 0 in [7:0]
//   data[31:0]        : payload word
//   crc[15:0]         : current checksum register
// -----------------------------------------------------------------------------
module crc_calculator (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        data_write,
    input  logic [1:0]  bytes_number,
    input  logic [31:0] data,
    output logic [15:0] crc
);

    logic [15:0] crc_r;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] byte_in);
        logic [15:0] c;
        c = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] word,
                                               input logic [1:0] last_byte);
        logic [15:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) <= {1'b0, last_byte}) begin
                c = crc16_byte(c, word[8*b +: 8]);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // Checksum register: seeded on reset/clear, updated per accepted word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_r <= 16'hFFFF;
        end else if (clear) begin
            crc_r <= 16'hFFFF;
        end else if (data_write) begin
            crc_r <= crc16_word(crc_r, data, bytes_number);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/ecc_calc.sv
// -----------------------------------------------------------------------------
// ecc_calc
// Combinational DSI packet-header ECC (Hamming-modified 24-bit code).
// Ports:
//   data [23:0] : {WC[15:8], WC[7:0], DI}, bit 0 = DI[0]
//   ecc  [7:0]  : {2'b00, P5..P0}
// -----------------------------------------------------------------------------
module ecc_calc (
    input  logic [23:0] data,
    output logic [7:0]  ecc
);

    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [7:0] p;
        p    = 8'h00;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    assign ecc = dsi_ecc(data);

endmodule

// File: rtl/dsi_packet_assembler.sv
// -----------------------------------------------------------------------------
// dsi_packet_assembler
// Builds one DSI packet at a time: a 4-byte header with ECC, then (long
// packets only) the payload streamed through unchanged while the CRC is
// accumulated, then a 2-byte checksum beat.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : dsi_packet_assembler_if.slave (pkt request, payload in, beats out,
//           busy)
// Parameter:
//   CRC_EMPTY : checksum emitted for a long packet with WC = 0
// -----------------------------------------------------------------------------
module dsi_packet_assembler
    import dsi_pkt_pkg::*;
#(
    parameter logic [15:0] CRC_EMPTY = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    dsi_packet_assembler_if.slave  bus
);

    dsi_state_e  state_r;
    logic [15:0] rem_r;
    logic [31:0] hdr_r;
    logic        long_r;
    logic        wc_zero_r;
    logic        pkt_ready_r;

    logic [7:0]  di_s;
    logic [7:0]  ecc_s;
    logic        pkt_fire_s;
    logic        pl_fire_s;
    logic [15:0] rem_take_s;
    logic [1:0]  pl_bytes_s;
    logic [15:0] crc_val_s;
    logic [15:0] crc_sel_s;

    logic        out_valid_s;
    logic [31:0] out_data_s;
    logic [1:0]  out_bytes_s;
    logic        out_last_s;
    logic        pl_ready_s;

    // Data Identifier from the requested VC/DT.
    always_comb begin
        di_s                      = 8'h00;
        di_s[DI_DT_MSB:DI_DT_LSB] = bus.pkt_dt;
        di_s[DI_VC_MSB:DI_VC_LSB] = bus.pkt_vc;
    end

    // pkt_ready_r is only ever high in IDLE, so it alone qualifies the request.
    assign pkt_fire_s = bus.pkt_valid & pkt_ready_r;
    assign pl_fire_s  = (state_r == ST_PAYLOAD) & bus.pl_valid & bus.out_ready;

    // Bytes consumed by the current payload word; saturates so rem never wraps.
    always_comb begin
        if (rem_r >= 16'd4) begin
            rem_take_s = 16'd4;
        end else begin
            rem_take_s = rem_r;
        end
        pl_bytes_s = 2'(rem_take_s - 16'd1);
    end

    assign crc_sel_s = wc_zero_r ? CRC_EMPTY : crc_val_s;

    ecc_calc u_ecc (
        .data ({bus.pkt_wc, di_s}),
        .ecc  (ecc_s)
    );

    crc_calculator u_crc (
        .clk          (clk),
        .reset_n      (~reset),
        .clear        (pkt_fire_s),
        .data_write   (pl_fire_s),
        .bytes_number (pl_bytes_s),
        .data         (bus.pl_data),
        .crc          (crc_val_s)
    );

    // Packet sequencer: captures the request and walks HEADER/PAYLOAD/CRC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rem_r       <= 16'd0;
            hdr_r       <= 32'd0;
            long_r      <= 1'b0;
            wc_zero_r   <= 1'b0;
            pkt_ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pkt_fire_s) begin
                        // Header word is frozen here, so it stays stable under stall.
                        hdr_r       <= {ecc_s, bus.pkt_wc, di_s};
                        long_r      <= bus.pkt_long;
                        wc_zero_r   <= (bus.pkt_wc == 16'd0);
                        rem_r       <= bus.pkt_wc;
                        pkt_ready_r <= 1'b0;
                        state_r     <= ST_HEADER;
                    end else begin
                        pkt_ready_r <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (bus.out_ready) begin
                        if (!long_r) begin
                            pkt_ready_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else if (wc_zero_r) begin
                            state_r <= ST_CRC;
                        end else begin
                            state_r <= ST_PAYLOAD;
                        end
                    end else begin
                        state_r <= ST_HEADER;
                    end
                end
                ST_PAYLOAD: begin
                    if (pl_fire_s) begin
                        rem_r <= rem_r - rem_take_s;
                        if (rem_r == rem_take_s) begin
                            state_r <= ST_CRC;
                        end else begin
                            state_r <= ST_PAYLOAD;
                        end
                    end else begin
                        state_r <= ST_PAYLOAD;
                    end
                end
                ST_CRC: begin
                    if (bus.out_ready) begin
                        pkt_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_CRC;
                    end
                end
                default: begin
                    pkt_ready_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Output beat mux: every field comes from a register except the payload
    // pass-through, which mirrors the (held-until-accepted) upstream source.
    always_comb begin
        out_valid_s = 1'b0;
        out_data_s  = 32'd0;
        out_bytes_s = 2'd0;
        out_last_s  = 1'b0;
        pl_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                out_valid_s = 1'b0;
            end
            ST_HEADER: begin
                out_valid_s = 1'b1;
                out_data_s  = hdr_r;
                out_bytes_s = 2'(DSI_HDR_BYTES - 1);
                out_last_s  = ~long_r;
            end
            ST_PAYLOAD: begin
                out_valid_s = bus.pl_valid;
                out_data_s  = bus.pl_data;
                out_bytes_s = pl_bytes_s;
                pl_ready_s  = bus.out_ready;
            end
            ST_CRC: begin
                out_valid_s = 1'b1;
                out_data_s  = {16'h0000, crc_sel_s};
                out_bytes_s = 2'(DSI_CRC_BYTES - 1);
                out_last_s  = 1'b1;
            end
            default: begin
                out_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.pkt_ready = pkt_ready_r;
    assign bus.pl_ready  = pl_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.out_bytes = out_bytes_s;
    assign bus.out_last  = out_last_s;
    assign bus.busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// -----------------------------------------------------------------------------
// tb_dsi_packet_assembler
// Directed bench for dsi_packet_assembler with hand-computed header/ECC and
// CRC values for short packets, empty long packets, the "123456789" payload,
// random output stalls, mid-packet reset and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_dsi_packet_assembler;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    dsi_packet_assembler_if bus();

    dsi_packet_assembler #(.CRC_EMPTY(16'hFFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_ovalid"}, {31'd0, bus.out_valid}, 32'd0);
        check_value({tag, "_odata"},  bus.out_data, 32'd0);
        check_value({tag, "_obytes"}, {30'd0, bus.out_bytes}, 32'd0);
        check_value({tag, "_olast"},  {31'd0, bus.out_last}, 32'd0);
        check_value({tag, "_plrdy"},  {31'd0, bus.pl_ready}, 32'd0);
        check_value({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
    endtask

    // Issue a request; keep pkt_valid high afterwards when hold is set.
    task automatic send_pkt(input string tag, input logic lng, input logic [1:0] vc,
                            input logic [5:0] dt, input logic [15:0] wc, input logic hold);
        int waited;
        waited        = 0;
        bus.pkt_long  = lng;
        bus.pkt_vc    = vc;
        bus.pkt_dt    = dt;
        bus.pkt_wc    = wc;
        bus.pkt_valid = 1'b1;
        #1;
        while (!bus.pkt_ready && waited < 20) begin
            step();
            waited++;
        end
        check_value({tag, "_pkt_ready"}, {31'd0, bus.pkt_ready}, 32'd1);
        step();
        bus.pkt_valid = hold;
        check_value({tag, "_hdr_latency"}, {31'd0, bus.out_valid}, 32'd1);
    endtask

    // Wait for a beat, check it, optionally stall, then accept it.
    task automatic take_beat(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_bytes,
                             input logic exp_last, input logic exp_plr, input int stall);
        int waited;
        waited        = 0;
        bus.out_ready = 1'b0;
        #1;
        while (!bus.out_valid && waited < 20) begin
            step();
            waited++;
        end
        check_value({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check_value({tag, "_data"},  bus.out_data, exp_data);
        check_value({tag, "_bytes"}, {30'd0, bus.out_bytes}, {30'd0, exp_bytes});
        check_value({tag, "_last"},  {31'd0, bus.out_last}, {31'd0, exp_last});
        for (int i = 0; i < stall; i++) begin
            step();
            check_value({tag, "_stall_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check_value({tag, "_stall_data"},  bus.out_data, exp_data);
        end
        bus.out_ready = 1'b1;
        #1;
        check_value({tag, "_pl_ready"}, {31'd0, bus.pl_ready}, {31'd0, exp_plr});
        step();
        bus.out_ready = 1'b0;
    endtask

    // WC=9 long packet carrying "123456789"; word3 upper bytes are don't-care.
    task automatic long9(input string tag, input logic [31:0] word3, input logic bp);
        send_pkt({tag, "_req"}, 1'b1, 2'd0, 6'h39, 16'd9, 1'b0);
        // Early payload must be held off during the header beat.
        bus.pl_valid = 1'b1;
        bus.pl_data  = 32'h34333231;
        take_beat({tag, "_hdr"}, 32'h30000939, 2'd3, 1'b0, 1'b0, bp ? int'($urandom_range(0, 3)) : 0);
        take_beat({tag, "_w0"}, 32'h34333231, 2'd3, 1'b0, 1'b1, bp ? int'($urandom_range(0, 3)) : 0);
        bus.pl_data = 32'h38373635;
        take_beat({tag, "_w1"}, 32'h38373635, 2'd3, 1'b0, 1'b1, bp ? int'($urandom_range(0, 3)) : 0);
        bus.pl_data = word3;
        take_beat({tag, "_w2"}, word3, 2'd0, 1'b0, 1'b1, bp ? int'($urandom_range(0, 3)) : 0);
        bus.pl_valid = 1'b0;
        bus.pl_data  = 32'd0;
        take_beat({tag, "_crc"}, 32'h00006F91, 2'd1, 1'b1, 1'b0, bp ? int'($urandom_range(0, 3)) : 0);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.pkt_long  = 1'b0;
        bus.pkt_vc    = 2'd0;
        bus.pkt_dt    = 6'd0;
        bus.pkt_wc    = 16'd0;
        bus.pl_valid  = 1'b0;
        bus.pl_data   = 32'd0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check_idle_outputs("rst");
        check_value("rst_pkt_ready", {31'd0, bus.pkt_ready}, 32'd0);
        reset = 1'b0;
        step();
        check_value("post_rst_pkt_ready", {31'd0, bus.pkt_ready}, 32'd1);
        check_idle_outputs("post_rst");

        // Short packets
        send_pkt("s1", 1'b0, 2'd0, 6'h05, 16'h0011, 1'b0);
        take_beat("s1_beat", 32'h36001105, 2'd3, 1'b1, 1'b0, 0);
        check_value("s1_busy_after", {31'd0, bus.busy}, 32'd0);
        send_pkt("s2", 1'b0, 2'd0, 6'h05, 16'h0029, 1'b0);
        take_beat("s2_beat", 32'h1C002905, 2'd3, 1'b1, 1'b0, 0);

        // Long packet, WC = 0
        send_pkt("l0", 1'b1, 2'd0, 6'h39, 16'h0000, 1'b0);
        take_beat("l0_hdr", 32'h0F000039, 2'd3, 1'b0, 1'b0, 0);
        take_beat("l0_crc", 32'h0000FFFF, 2'd1, 1'b1, 1'b0, 0);

        // Long packet, WC = 9
        long9("l9", 32'h00000039, 1'b0);

        // Backpressure; junk above the last valid byte must not reach the CRC
        long9("bp", 32'hDEADBE39, 1'b1);

        // Reset mid-PAYLOAD after the first word
        send_pkt("mr", 1'b1, 2'd0, 6'h39, 16'd9, 1'b0);
        bus.pl_valid = 1'b1;
        bus.pl_data  = 32'h34333231;
        take_beat("mr_hdr", 32'h30000939, 2'd3, 1'b0, 1'b0, 0);
        take_beat("mr_w0", 32'h34333231, 2'd3, 1'b0, 1'b1, 0);
        bus.pl_data = 32'h38373635;
        reset       = 1'b1;
        #1;
        check_idle_outputs("mr_rst");
        step();
        bus.pl_valid = 1'b0;
        bus.pl_data  = 32'd0;
        reset        = 1'b0;
        step();
        long9("mr_after", 32'h00000039, 1'b0);

        // Back-to-back long packets with pkt_valid held high
        send_pkt("bb_a", 1'b1, 2'd0, 6'h39, 16'h0000, 1'b1);
        bus.pkt_vc = 2'd1;
        check_value("bb_wait_pkt_ready", {31'd0, bus.pkt_ready}, 32'd0);
        take_beat("bb_a_hdr", 32'h0F000039, 2'd3, 1'b0, 1'b0, 0);
        take_beat("bb_a_crc", 32'h0000FFFF, 2'd1, 1'b1, 1'b0, 0);
        check_value("bb_gap_valid", {31'd0, bus.out_valid}, 32'd0);
        check_value("bb_gap_pkt_ready", {31'd0, bus.pkt_ready}, 32'd1);
        check_value("bb_gap_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
        step();
        bus.pkt_valid = 1'b0;
        check_value("bb_b_valid", {31'd0, bus.out_valid}, 32'd1);
        check_value("bb_b_data", bus.out_data, 32'h19000079);
        take_beat("bb_b_hdr", 32'h19000079, 2'd3, 1'b0, 1'b0, 0);
        take_beat("bb_b_crc", 32'h0000FFFF, 2'd1, 1'b1, 1'b0, 0);
        check_value("bb_end_busy", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
